// File: rtl/race_pkg.sv
// Shared race-game codes: sequencer state encoding and the operation codes
// exchanged between the encoder, display and sequencer.
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_SYNCING   = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } race_state_t;

  typedef enum logic [2:0] {
    OP_NIL      = 3'd0,
    OP_FORWARD  = 3'd1,
    OP_BACKWARD = 3'd2,
    OP_LEFT     = 3'd3,
    OP_RIGHT    = 3'd4
  } race_op_t;

  // States in which the timing tick prescaler advances.
  function automatic logic tick_running(input race_state_t s);
    return (s == ST_SYNCING) || (s == ST_COUNTDOWN) || (s == ST_RACING);
  endfunction

endpackage

// File: rtl/race_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_CYCLES-1 while enabled and not held,
// pulsing tick for one cycle at the terminal count.
module race_tick_gen #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_reg;
  logic          advance;

  assign advance = enable && !hold;
  assign tick    = advance && (count_reg == TERMINAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (advance) begin
      count_reg <= (count_reg == TERMINAL) ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/race_phase_controller.sv
// Master race sequencer: game state FSM plus countdown digit, lap counter,
// saturating race timer and win flag.
module race_phase_controller
  import race_pkg::*;
#(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int COUNT_FROM   = 3,
  parameter int LAPS         = 3,
  parameter int SYNC_TIMEOUT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  input  logic        confirm_req,
  input  logic        pause_req,
  input  logic        abort_req,
  input  logic        peer_ready,
  input  logic        peer_finished,
  input  logic        lap_pulse,
  output logic [2:0]  state,
  output logic        local_ready,
  output logic [1:0]  countdown,
  output logic [2:0]  lap_count,
  output logic [15:0] race_time,
  output logic        won
);

  localparam int SW = $clog2(SYNC_TIMEOUT + 1);

  race_state_t   state_reg, state_next;
  logic [1:0]    countdown_reg, countdown_next;
  logic [2:0]    lap_reg, lap_next;
  logic [15:0]   time_reg, time_next;
  logic          won_reg, won_next;
  logic          ready_reg;
  logic [SW-1:0] sync_reg, sync_next;
  logic [SW-1:0] sync_inc;
  logic [2:0]    lap_inc;
  logic          local_finish;
  logic          tick, tick_clear, pause_toggle;

  assign sync_inc     = sync_reg + 1'b1;
  assign lap_inc      = lap_reg + 3'd1;
  assign local_finish = lap_pulse && (lap_inc == 3'(LAPS));

  // The prescaler keeps its phase across a pause so resuming does not
  // shorten or stretch the current race_time tick.
  assign pause_toggle = ((state_reg == ST_RACING) && (state_next == ST_PAUSE)) ||
                        ((state_reg == ST_PAUSE) && (state_next == ST_RACING));
  assign tick_clear   = (state_next != state_reg) && !pause_toggle;

  race_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(tick_running(state_reg)),
    .clear (tick_clear),
    .hold  (state_reg == ST_PAUSE),
    .tick  (tick)
  );

  always_comb begin
    state_next     = state_reg;
    countdown_next = countdown_reg;
    lap_next       = lap_reg;
    time_next      = time_reg;
    won_next       = won_reg;
    sync_next      = sync_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_req) state_next = ST_SETTING;
      end
      ST_SETTING: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (confirm_req) begin
          state_next = ST_SYNCING;
          sync_next  = '0;
        end
      end
      ST_SYNCING: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (peer_ready) begin
          state_next     = ST_COUNTDOWN;
          countdown_next = 2'(COUNT_FROM);
        end else if (tick) begin
          if (sync_inc == SW'(SYNC_TIMEOUT)) state_next = ST_SETTING;
          else                               sync_next  = sync_inc;
        end
      end
      ST_COUNTDOWN: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (countdown_reg > 2'd1) begin
            countdown_next = countdown_reg - 2'd1;
          end else begin
            state_next     = ST_RACING;
            countdown_next = 2'd0;
          end
        end
      end
      ST_RACING: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else begin
          if (tick && (time_reg != 16'hFFFF)) time_next = time_reg + 16'd1;
          if (lap_pulse) lap_next = lap_inc;
          if (local_finish) begin
            state_next = ST_FINISH;
            won_next   = !peer_finished;
          end else if (peer_finished) begin
            state_next = ST_FINISH;
            won_next   = 1'b0;
          end else if (pause_req) begin
            state_next = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (abort_req)      state_next = ST_IDLE;
        else if (pause_req) state_next = ST_RACING;
      end
      ST_FINISH: begin
        if (abort_req || start_req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_IDLE) begin
      countdown_next = 2'd0;
      lap_next       = 3'd0;
      time_next      = 16'd0;
      won_next       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      countdown_reg <= 2'd0;
      lap_reg       <= 3'd0;
      time_reg      <= 16'd0;
      won_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      sync_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      countdown_reg <= countdown_next;
      lap_reg       <= lap_next;
      time_reg      <= time_next;
      won_reg       <= won_next;
      ready_reg     <= (state_next == ST_SYNCING);
      sync_reg      <= sync_next;
    end
  end

  assign state       = state_reg;
  assign local_ready = ready_reg;
  assign countdown   = countdown_reg;
  assign lap_count   = lap_reg;
  assign race_time   = time_reg;
  assign won         = won_reg;

endmodule

// File: doc/race_phase_controller.md
Name: race_phase_controller

Overview:
- Master race sequencer: owns the 3-bit game state consumed by the operation encoder, display and audio blocks.
- Walks IDLE → SETTING → SYNCING → COUNTDOWN → RACING ⇄ PAUSE → FINISH from single-cycle key events, the peer-board handshake and lap-completion pulses.
- Keeps the countdown digit, lap counter, race timer and win flag.

Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per timing tick (1 s at 100 MHz); benches shrink it.
- COUNT_FROM, 3: countdown start digit, 1..3.
- LAPS, 3: laps to finish, 1..7.
- SYNC_TIMEOUT, 10: ticks in SYNCING before giving up.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start_req  in  1  one-cycle pulse (start/restart key).
- confirm_req  in  1  one-cycle pulse (settings confirmed).
- pause_req  in  1  one-cycle pulse (pause toggle).
- abort_req  in  1  one-cycle pulse (return to IDLE).
- peer_ready  in  1  level; peer board in SYNCING; already synchronised to clk.
- peer_finished  in  1  level; peer crossed the finish line; already synchronised.
- lap_pulse  in  1  one-cycle pulse from the track checker.
- state  out  3  IDLE=0, SETTING=1, SYNCING=2, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6.
- local_ready  out  1  high exactly while state==SYNCING.
- countdown  out  2  digit shown during COUNTDOWN.
- lap_count  out  3  completed laps.
- race_time  out  16  ticks spent in RACING, saturating.
- won  out  1  valid in FINISH.

Behaviour:
- Reset (async assert; release takes effect on the next clk edge):
  - state=IDLE, countdown=0, lap_count=0, race_time=0, won=0, local_ready=0, prescaler=0.
- All outputs are registered. Input sampled at edge N → new state visible after edge N.
- Tick prescaler:
  - Counts 0..TICK_CYCLES-1 and raises an internal one-cycle tick at terminal count.
  - Runs only in SYNCING, COUNTDOWN and RACING.
  - Held, not cleared, across RACING⇄PAUSE.
  - Cleared on every other state change.
- Transition priority per cycle: abort_req > local finish > peer finish > tick/lap > pause_req.
- IDLE:
  - start_req → SETTING.
  - Entering IDLE clears lap_count, race_time, won and countdown.
- SETTING:
  - confirm_req → SYNCING and clear the sync tick counter.
  - abort_req → IDLE.
- SYNCING:
  - local_ready=1.
  - peer_ready high → COUNTDOWN with countdown=COUNT_FROM.
  - Otherwise, the tick that brings sync ticks to SYNC_TIMEOUT → back to SETTING.
  - If peer_ready and the timeout coincide, peer_ready wins.
- COUNTDOWN:
  - Each tick with countdown>1 decrements it.
  - A tick with countdown==1 → RACING and countdown=0.
  - lap_pulse is ignored.
- RACING:
  - Each tick: race_time+1, saturating at 0xFFFF.
  - lap_pulse: lap_count+1. If the new value equals LAPS → FINISH with won = !peer_finished.
  - peer_finished high with no local finish that cycle → FINISH with won=0.
  - pause_req → PAUSE, but only when no finish occurs that cycle.
- PAUSE:
  - race_time and prescaler frozen; lap_pulse ignored.
  - pause_req → RACING.
  - peer_finished does not finish the race until play resumes.
- FINISH:
  - All counters hold.
  - start_req → IDLE.
- abort_req in any non-IDLE state → IDLE next cycle.
- state==7 (unreachable) → IDLE next cycle.
- Inputs are pulses. Held levels on the *_req inputs are not edge-detected; the producer must pulse them.

Decomposition:
- Shared package (race_pkg): the state codes 0..6 and operation codes NIL/FORWARD/BACKWARD/LEFT/RIGHT. The operation encoder, display and this block all import them.
- One sub-module: race_tick_gen, holding the prescaler with enable, clear and hold inputs and a tick output.
- The FSM and counters stay in race_phase_controller.

Test Plan (TICK_CYCLES=4, COUNT_FROM=3, LAPS=2, SYNC_TIMEOUT=5):
- Reset mid-RACING:
  - Stimulus: assert rst between edges.
  - Required: state=0, race_time=0, lap_count=0 immediately, without waiting for an edge.
- Happy path:
  - Stimulus: start_req, confirm_req, then peer_ready=1.
  - Required: state 0→1→2→3 one cycle per event.
  - Required: countdown 3,2,1 at 4-cycle spacing, then state=4 with countdown=0.
  - Stimulus: two lap_pulses.
  - Required: state=6, lap_count=2, won=1.
- Sync timeout:
  - Stimulus: confirm_req with peer_ready=0.
  - Required: state=2 for 20 cycles, then state=1.
  - Stimulus: peer_ready=1 in the same cycle as the 5th tick.
  - Required: state=3.
- Pause freeze:
  - Stimulus: race_time=5, pause_req, 40 idle cycles, lap_pulse.
  - Required: race_time stays 5, lap_count unchanged.
  - Stimulus: pause_req again.
  - Required: state=4, race_time reaches 6 after the remaining prescaler cycles.
- Simultaneous events:
  - Final lap_pulse, peer_finished=1 and pause_req in one cycle → state=6, won=0.
  - peer_finished=1 alone at lap 1 → state=6, won=0.
- Abort:
  - Stimulus: abort_req in COUNTDOWN, and separately in PAUSE.
  - Required: state=0 next cycle with all counters cleared.
  - Stimulus: start_req in FINISH.
  - Required: state=0.
